// File: rtl/kc87_pkg.sv
// Shared constants and types for the KC87 interrupt controller.
// Nesting behaviour is selected by the KC87_INT_NESTING_EN macro (see kc87_int_prio).
package kc87_pkg;

    localparam int         NUM_INT_SRC      = 4;
    localparam int         SRC_IDX_W        = $clog2(NUM_INT_SRC);
    localparam logic [7:0] SPURIOUS_VEC_DEF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } int_state_e;

endpackage

// File: rtl/kc87_int_ctrl_if.sv
// Source/CPU-side bus of the KC87 interrupt controller.
// master = CPU and interrupt sources, slave = controller.
interface kc87_int_ctrl_if
    import kc87_pkg::*;
;
    logic [NUM_INT_SRC-1:0]   int_req;
    logic [8*NUM_INT_SRC-1:0] src_vec;
    logic                     m1_n;
    logic                     iorq_n;
    logic                     reti_n;
    logic                     int_n;
    logic [NUM_INT_SRC-1:0]   int_ack;
    logic [7:0]               vec_out;
    logic                     vec_oe;
    logic [NUM_INT_SRC-1:0]   in_service;

    modport master (
        output int_req, src_vec, m1_n, iorq_n, reti_n,
        input  int_n, int_ack, vec_out, vec_oe, in_service
    );

    modport slave (
        input  int_req, src_vec, m1_n, iorq_n, reti_n,
        output int_n, int_ack, vec_out, vec_oe, in_service
    );

endinterface

// File: rtl/kc87_int_prio.sv
// Combinational eligibility filter and lowest-index priority encoder.
// KC87_INT_NESTING_EN defined: a source may preempt any in-service source of lower priority.
module kc87_int_prio
    import kc87_pkg::*;
(
    input  logic [NUM_INT_SRC-1:0] int_req,
    input  logic [NUM_INT_SRC-1:0] in_service,
    output logic [NUM_INT_SRC-1:0] grant,
    output logic [SRC_IDX_W-1:0]   grant_idx,
    output logic                   grant_vld
);

    logic [NUM_INT_SRC-1:0] eligible;

`ifdef KC87_INT_NESTING_EN
    logic blocked;

    // Any in-service bit at or below index i masks source i and everything after it.
    always_comb begin
        eligible = '0;
        blocked  = 1'b0;
        for (int i = 0; i < NUM_INT_SRC; i++) begin
            blocked     = blocked | in_service[i];
            eligible[i] = int_req[i] & ~blocked;
        end
    end
`else
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_INT_SRC; i++)
            eligible[i] = int_req[i] & ~(|in_service);
    end
`endif

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int i = NUM_INT_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = SRC_IDX_W'(i);
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/kc87_int_ctrl.sv
// Z80-style interrupt controller: request/acknowledge sequencing, vector drive and in-service tracking.
// Build option KC87_INT_NESTING_EN enables priority nesting.
module kc87_int_ctrl
    import kc87_pkg::*;
#(
    parameter logic [7:0] SPURIOUS_VEC = SPURIOUS_VEC_DEF
) (
    input  logic           clk,
    input  logic           reset,
    kc87_int_ctrl_if.slave bus
);

    int_state_e             state, state_nxt;
    logic                   inta, inta_d, inta_start;
    logic                   reti_d, reti_edge;
    logic [NUM_INT_SRC-1:0] grant;
    logic [SRC_IDX_W-1:0]   grant_idx;
    logic                   grant_vld;
    logic [NUM_INT_SRC-1:0] in_service_q, in_service_nxt;
    logic [NUM_INT_SRC-1:0] int_ack_q;
    logic [7:0]             vec_q;

    assign inta       = ~bus.m1_n & ~bus.iorq_n;
    assign inta_start = inta & ~inta_d;
    assign reti_edge  = ~bus.reti_n & reti_d;

    kc87_int_prio u_prio (
        .int_req    (bus.int_req),
        .in_service (in_service_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_vld  (grant_vld)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (inta_start) begin
            state_nxt = ACK;
        end else begin
            case (state)
                IDLE:    if (grant_vld) state_nxt = REQ;
                REQ:     if (!grant_vld) state_nxt = IDLE;
                ACK:     if (!inta) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.int_n  = (state != REQ);
        bus.vec_oe = (state == ACK) && inta;
    end

    // RETI retires from the pre-acknowledge set; a same-cycle grant is added afterwards.
    always_comb begin
        in_service_nxt = in_service_q;
        if (reti_edge)
            in_service_nxt = in_service_nxt & (in_service_nxt - NUM_INT_SRC'(1));
        if (inta_start && grant_vld)
            in_service_nxt = in_service_nxt | grant;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inta_d       <= 1'b0;
            reti_d       <= 1'b1;
            in_service_q <= '0;
            int_ack_q    <= '0;
            vec_q        <= 8'h00;
        end else begin
            inta_d       <= inta;
            reti_d       <= bus.reti_n;
            in_service_q <= in_service_nxt;
            int_ack_q    <= (inta_start && grant_vld) ? grant : '0;
            if (inta_start)
                vec_q <= grant_vld ? bus.src_vec[8*grant_idx +: 8] : SPURIOUS_VEC;
        end
    end

    assign bus.in_service = in_service_q;
    assign bus.int_ack    = int_ack_q;
    assign bus.vec_out    = vec_q;

endmodule

// File: doc/kc87_int_ctrl.md
KC87_INT_CTRL -- requirements
Module: kc87_int_ctrl

Interface
REQ-001 Parameter SPURIOUS_VEC, default 8'hFF, vector driven when an acknowledge finds no eligible source.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 int_req  input  4  per-source level request; bit 0 is the highest priority, bit 3 the lowest.
REQ-005 src_vec  input  32  per-source vector; byte i (bits 8i+7:8i) belongs to source i.
REQ-006 m1_n  input  1  CPU M1, active low.
REQ-007 iorq_n  input  1  CPU IORQ, active low; m1_n=0 and iorq_n=0 together define an interrupt-acknowledge (INTA) cycle.
REQ-008 reti_n  input  1  CPU RETI strobe, active low, at least one clk wide.
REQ-009 int_n  output  1  registered interrupt request to the CPU, active low.
REQ-010 int_ack  output  4  one-clk, one-hot acknowledge pulse to the granted source.
REQ-011 vec_out  output  8  vector for the CPU data bus.
REQ-012 vec_oe  output  1  high while vec_out must be placed on the CPU data bus.
REQ-013 in_service  output  4  in-service flags, one per source.

Function
REQ-014 The FSM SHALL have three states: IDLE, REQ and ACK.
REQ-015 Source i SHALL be eligible when int_req[i]=1, in_service[i]=0 and i is lower than the index of every set in_service bit.
REQ-016 The winner SHALL be the lowest-index eligible source.
REQ-017 IDLE->REQ SHALL occur on the first clk in which an eligible source exists, so int_n falls one clk after the request appears.
REQ-018 REQ->IDLE SHALL occur if the eligible set becomes empty before INTA, and int_n SHALL return high on the next clk.
REQ-019 int_n SHALL be 0 exactly while the FSM is in REQ.
REQ-020 INTA start is the first clk with m1_n=0 and iorq_n=0 after a clk in which that condition was false; from any state the FSM SHALL go to ACK on INTA start.
REQ-021 On INTA start with a winner w: latch w, set in_service[w], pulse int_ack[w] for one clk, and load vec_out with src_vec byte w.
REQ-022 On INTA start with no eligible source: load vec_out with SPURIOUS_VEC; in_service and int_ack SHALL remain unchanged.
REQ-023 vec_oe SHALL be 1 while the FSM is in ACK and m1_n=0 and iorq_n=0, and 0 otherwise.
REQ-024 vec_out SHALL be held stable for the whole ACK period.
REQ-025 ACK->IDLE SHALL occur on the first clk with m1_n=1 or iorq_n=1.
REQ-026 A reti_n falling edge (reti_n=0 with reti_n=1 in the previous clk) SHALL clear the lowest-index set in_service bit; with no bit set it SHALL have no effect.
REQ-027 If a RETI edge and an INTA start fall in the same clk, RETI SHALL clear from the pre-INTA in_service value, and the INTA set SHALL then be applied.
REQ-028 The winner SHALL be sampled only at INTA start; request changes during ACK SHALL NOT affect vec_out.

Reset
REQ-029 While reset=1: FSM=IDLE, int_n=1, int_ack=0, vec_out=8'h00, vec_oe=0, in_service=0, and the edge-detect registers for INTA and reti_n SHALL be loaded with their inactive values.
REQ-030 Reset asserted during REQ or ACK SHALL abort the cycle with no int_ack pulse.

Configuration
REQ-031 Macro KC87_INT_NESTING_EN.
- Defined: nesting per REQ-015.
- Undefined: a source SHALL be eligible only when in_service is all zero.

Structure
REQ-032 Package kc87_pkg SHALL hold:
- NUM_INT_SRC=4
- the FSM state typedef (IDLE, REQ, ACK)
- the default spurious vector constant 8'hFF
REQ-033 The lowest-index eligibility/priority encoder SHALL be the sub-module kc87_int_prio, purely combinational; the sequencing logic SHALL stay in kc87_int_ctrl.

Verification
REQ-034 Single source: int_req=4'b0100, src_vec byte2=8'h24, then INTA -> int_n low 1 clk after the request; int_ack=4'b0100 for 1 clk; vec_out=8'h24 with vec_oe=1 during INTA; in_service=4'b0100.
REQ-035 Simultaneous requests: int_req=4'b1010 -> source 1 wins; vec_out=byte1; int_ack=4'b0010.
REQ-036 Nesting:
- Setup: in_service=4'b1000; source 0 requests.
- With KC87_INT_NESTING_EN: int_n goes low and in_service becomes 4'b1001; one RETI then yields 4'b1000.
- Without the macro: int_n stays high.
REQ-037 Withdrawn request: int_req 4'b0001 for 3 clk then 0 before INTA, then INTA -> int_n returns high; the INTA gives vec_out=8'hFF, int_ack=0 and no in_service change.
REQ-038 Reset mid-ACK: reset during INTA -> vec_oe=0, int_n=1 and in_service=0 immediately.
